// File: rtl/bin_to_bcd.sv
// Sequential binary-to-packed-BCD converter using shift-and-add-3, one input bit per clock.
// A start pulse in IDLE launches a conversion; done pulses once when the registered outputs update.
module bin_to_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [WIDTH-1:0]                 bin_in,
    output logic                             busy,
    output logic                             done,
    output logic [4*DIGITS-1:0]              bcd_out,
    output logic [$clog2(DIGITS+1)-1:0]      ndigits,
    output logic                             ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int NW = $clog2(DIGITS + 1);

    // The FINISH step happens on the last SHIFT edge, so only two encoded states remain.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            cy_q, cy_d;
    logic            done_q, done_d;
    logic [BW-1:0]   bcd_out_q, bcd_out_d;
    logic [NW-1:0]   nd_q, nd_d;
    logic            ovf_q, ovf_d;

    logic [BW-1:0]   adj;
    logic [BW-1:0]   bcd_sh;
    logic            cout;
    logic [NW-1:0]   nd_sh;

    // Per-digit +3 correction, then the combined {bcd, bin} left shift.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = bcd_q[4*i +: 4] + ((bcd_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
        end
        bcd_sh = {adj[BW-2:0], bin_q[WIDTH-1]};
        cout   = adj[BW-1];
        nd_sh  = NW'(1);
        for (int i = 1; i < DIGITS; i++) begin
            if (bcd_sh[4*i +: 4] != 4'd0) begin
                nd_sh = NW'(i + 1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cy_d      = cy_q;
        done_d    = 1'b0;
        bcd_out_d = bcd_out_q;
        nd_d      = nd_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    bin_d   = bin_in;
                    bcd_d   = '0;
                    cy_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                bcd_d = bcd_sh;
                bin_d = bin_q << 1;
                cy_d  = cy_q | cout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    done_d    = 1'b1;
                    bcd_out_d = bcd_sh;
                    ovf_d     = cy_q | cout;
                    nd_d      = nd_sh;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            cy_q      <= 1'b0;
            done_q    <= 1'b0;
            bcd_out_q <= '0;
            nd_q      <= NW'(1);
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cy_q      <= cy_d;
            done_q    <= done_d;
            bcd_out_q <= bcd_out_d;
            nd_q      <= nd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy    = (state_q == ST_SHIFT);
    assign done    = done_q;
    assign bcd_out = bcd_out_q;
    assign ndigits = nd_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Bench for bin_to_bcd: a 3-digit and a 2-digit instance share stimulus and are scored
// against decimal arithmetic, with exact latency, busy window and reset behaviour.
module tb_bin_to_bcd;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] bin_in;

    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;
    logic [1:0]  nd3;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;
    logic [1:0]  nd2;

    int total = 0;
    int bad   = 0;

    // Expected results: [11:0] packed BCD, [13:12] ndigits, [14] ovf.
    logic [15:0] exp3_q[$];
    logic [15:0] exp2_q[$];

    bin_to_bcd #(.WIDTH(8), .DIGITS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy3), .done(done3), .bcd_out(bcd3), .ndigits(nd3), .ovf(ovf3)
    );

    bin_to_bcd #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .ndigits(nd2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Decimal reference: digits of v mod 10^d, count of significant digits, overflow flag.
    function automatic logic [15:0] model(input int v, input int d);
        int pow, m, x, n, bcd;
        pow = 1;
        for (int i = 0; i < d; i++) pow = pow * 10;
        m   = v % pow;
        bcd = 0;
        x   = m;
        for (int i = 0; i < d; i++) begin
            bcd = bcd + ((x % 10) << (4 * i));
            x   = x / 10;
        end
        n = 0;
        x = m;
        while (x > 0) begin
            n++;
            x = x / 10;
        end
        if (n == 0) n = 1;
        model = {1'b0, (v >= pow), 2'(n), 12'(bcd)};
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done3) begin
            check("done3_while_busy", busy3, 0);
            check("done3_pending", exp3_q.size() != 0, 1);
            if (exp3_q.size() != 0) begin
                logic [15:0] e;
                e = exp3_q.pop_front();
                check("bcd3", bcd3, e[11:0]);
                check("nd3", nd3, e[13:12]);
                check("ovf3", ovf3, e[14]);
            end
        end
        if (done2) begin
            check("done2_while_busy", busy2, 0);
            check("done2_pending", exp2_q.size() != 0, 1);
            if (exp2_q.size() != 0) begin
                logic [15:0] e;
                e = exp2_q.pop_front();
                check("bcd2", bcd2, e[7:0]);
                check("nd2", nd2, e[13:12]);
                check("ovf2", ovf2, e[14]);
            end
        end
    end

    task automatic push_exp(input int v);
        exp3_q.push_back(model(v, 3));
        exp2_q.push_back(model(v, 2));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy3, 0);
        check({tag, "_done"}, done3, 0);
        check({tag, "_bcd"}, bcd3, 12'h000);
        check({tag, "_nd"}, nd3, 1);
        check({tag, "_ovf"}, ovf3, 0);
        check({tag, "_bcd2"}, bcd2, 8'h00);
        check({tag, "_nd2"}, nd2, 1);
    endtask

    // Called at a negedge; start is accepted on the next posedge (edge E).
    // Checks busy over the 8 following cycles and done exactly after edge E+8.
    task automatic run_conv(input logic [7:0] v, input bit mid_start);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        #1;
        push_exp(int'(v));
        start  = 1'b0;
        bin_in = 8'($urandom_range(0, 255));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("busy_window", busy3, 1);
            check("busy_window2", busy2, 1);
            check("no_early_done", done3, 0);
            if (mid_start && k == 3) begin
                start  = 1'b1;
                bin_in = 8'd200;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("busy_end", busy3, 0);
        check("done_latency", done3, 1);
        check("done_latency2", done2, 1);
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done3, 0);
        check("idle_not_busy", busy3, 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b1;
        bin_in = 8'd255;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst_release");

        run_conv(8'd255, 1'b0);
        idle_cycle();
        run_conv(8'd0, 1'b0);
        run_conv(8'd7, 1'b0);
        run_conv(8'd100, 1'b0);
        run_conv(8'd99, 1'b0);
        idle_cycle();

        // Mid-conversion start is ignored; 200 then goes in back-to-back from the done cycle.
        run_conv(8'd42, 1'b1);
        run_conv(8'd200, 1'b0);
        idle_cycle();

        // Start held high retriggers from every IDLE edge.
        start  = 1'b1;
        bin_in = 8'd55;
        push_exp(55);
        push_exp(55);
        repeat (18) @(negedge clk);
        idle_cycle();
        check("held_start_drained", exp3_q.size(), 0);

        // Reset in the middle of a conversion.
        start  = 1'b1;
        bin_in = 8'd123;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        exp3_q.delete();
        exp2_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("post_rst_idle_done", done3, 0);
            check("post_rst_idle_busy", busy3, 0);
        end
        run_conv(8'd123, 1'b0);
        idle_cycle();

        for (int n = 0; n < 40; n++) begin
            run_conv(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        run_conv(8'd0, 1'b0);
        run_conv(8'd255, 1'b0);
        idle_cycle();

        check("sb3_drained", exp3_q.size(), 0);
        check("sb2_drained", exp2_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
